hs_tx_sequencer: RTL and testbench
==================================

Name: hs_tx_sequencer

Overview:
Word-rate HS burst sequencer feeding the HS serializer. It frames each C-PHY HS burst: preamble words, sync word, payload words taken over a valid/ready handshake, then post words. It drives the 7-symbol {Flip,Rotation,Polarity} word lanes and the serializer enable. It sits between the HS protocol/lane-control logic and the serializer, in the TxWordClkHs domain.

Parameters:
PRE_WORDS, 2, number of preamble words (all symbol 3) per burst; legal range 1..15
POST_WORDS, 1, number of post words (all symbol 4) per burst; legal range 1..15
CNT_W, 4, width of the internal preamble/post word counter

Ports:
TxWordClkHs  input  1  word clock; all logic on its rising edge
rst  input  1  asynchronous, active-low reset
TxRequestHs  input  1  burst request; high for the burst duration
TxWordValid  input  1  payload word valid
TxWordReady  output  1  payload word accepted this cycle when high with TxWordValid
InFlip  input  7  payload flip bits; bit i is symbol i, bit 0 is sent first
InRotation  input  7  payload rotation bits
InPolarity  input  7  payload polarity bits
TxFlip  output  7  word to serializer
TxRotation  output  7  word to serializer
TxPolarity  output  7  word to serializer
SerializerEn  output  1  serializer enable
TxBusy  output  1  high whenever state != IDLE

Behaviour:
- Symbol code {flip,rot,pol}: symbol 3 = 011, symbol 4 = 100.
- Reset (asynchronous, active-low): rst low forces state IDLE, counter 0, TxFlip/TxRotation/TxPolarity = 0, SerializerEn = 0. Reset mid-burst aborts immediately with no post words.
- All outputs are registered except TxWordReady and TxBusy, which decode the current state.
- TxWordReady = TxRequestHs && (state == SYNC || state == DATA).
- IDLE: outputs 0, SerializerEn 0. On an edge with TxRequestHs = 1: load the preamble word (Flip = 0x00, Rotation = 0x7F, Polarity = 0x7F), set SerializerEn = 1, counter = 1, go to PREAMBLE. The first preamble word is visible one edge after the request is sampled.
- PREAMBLE: if counter < PRE_WORDS, hold the preamble word and increment the counter. Otherwise load the sync word (symbols 3,4,4,4,4,4,3 in positions 0..6: Flip = 0x3E, Rotation = 0x41, Polarity = 0x41) and go to SYNC. TxRequestHs is ignored in this state.
- SYNC and DATA share the same next-state logic:
  - Request high, valid high: load In* into the outputs (word accepted), go to DATA.
  - Request high, valid low (underrun): load the sync word as filler, go to DATA.
  - Request low: load the post word (Flip = 0x7F, Rotation = 0, Polarity = 0), counter = 1, go to POST. TxWordValid is ignored.
- POST: if counter < POST_WORDS, hold the post word and increment the counter. Otherwise clear the outputs to 0, set SerializerEn = 0, go to IDLE. TxRequestHs is ignored.
- A request that is high on the edge leaving POST is not seen until the next edge in IDLE. Back-to-back bursts therefore have at least one idle word.
- Burst length in words = PRE_WORDS + 1 + accepted words + fillers + POST_WORDS.
- Counter saturation cannot occur within the legal parameter ranges.

Optional Feature:
HS_TX_UNDERRUN_CNT_EN: when defined, adds output UnderrunCnt [7:0].
- Increments on each filler sync word loaded in SYNC/DATA and saturates at 0xFF.
- Clears on reset and on the IDLE->PREAMBLE transition.
When undefined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package hs_tx_pkg holds:
  - state enum (IDLE, PREAMBLE, SYNC, DATA, POST)
  - symbol codes SYM3 = 3'b011, SYM4 = 3'b100
  - 21-bit word constants PREAMBLE_WORD, SYNC_WORD, POST_WORD, ordered {Flip, Rotation, Polarity}
- The serializer reuses the package. No sub-module is needed; the FSM and counter sit in one module.

Test Plan:
1. Reset, then TxRequestHs high for 1 payload word (In = 0x55/0x2A/0x11, valid), PRE_WORDS = 2, POST_WORDS = 1 -> output sequence: preamble ×2, sync, {0x55,0x2A,0x11}, post ×1, then IDLE. SerializerEn high for exactly 5 cycles.
2. Request held, TxWordValid low for 3 cycles in DATA -> 3 sync filler words; UnderrunCnt = 3 with HS_TX_UNDERRUN_CNT_EN.
3. Request drops on the same edge TxWordValid is high in DATA -> post word loaded, TxWordReady = 0, the word is not consumed.
4. rst pulled low during PREAMBLE and during DATA -> outputs 0 and SerializerEn 0 immediately (asynchronous); after release, state IDLE and no post words.
5. Request pulse during PREAMBLE/POST, and request re-asserted on the edge leaving POST -> ignored; the next burst starts only after ≥1 IDLE cycle.
6. PRE_WORDS = 1, POST_WORDS = 3 -> 1 preamble word, 3 post words; cross-check the serializer output symbol stream (3,3…,3,4,4,4,4,4,3,…).

Source files
------------

// File: rtl/hs_tx_pkg.sv
// hs_tx_pkg: shared definitions for the C-PHY HS transmit word path.
// Holds the burst sequencer state encoding, the C-PHY symbol codes and the
// 21-bit framing words ordered {Flip[6:0], Rotation[6:0], Polarity[6:0]}.
// Each framing word is built from its symbol sequence, so the hex values
// follow from the symbol codes and are not typed in by hand.
package hs_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        DATA,
        POST
    } state_t;

    // Symbol code {flip, rotation, polarity}
    localparam logic [2:0] SYM3 = 3'b011;
    localparam logic [2:0] SYM4 = 3'b100;

    localparam int WORD_W = 21;

    // Spread seven 3-bit symbols (index 0 is sent first) across the three
    // 7-bit lanes, so that bit i of every lane belongs to symbol i.
    function automatic logic [WORD_W-1:0] sym_word(input logic [6:0][2:0] syms);
        logic [6:0] flip;
        logic [6:0] rot;
        logic [6:0] pol;
        for (int i = 0; i < 7; i++) begin
            flip[i] = syms[i][2];
            rot[i]  = syms[i][1];
            pol[i]  = syms[i][0];
        end
        return {flip, rot, pol};
    endfunction

    // Concatenations list symbol 6 first and symbol 0 last
    localparam logic [WORD_W-1:0] PREAMBLE_WORD = sym_word({7{SYM3}});
    localparam logic [WORD_W-1:0] SYNC_WORD     =
        sym_word({SYM3, SYM4, SYM4, SYM4, SYM4, SYM4, SYM3});
    localparam logic [WORD_W-1:0] POST_WORD     = sym_word({7{SYM4}});

endpackage

// File: rtl/hs_tx_sequencer_if.sv
// hs_tx_sequencer_if: payload handshake and serializer word bus of the HS
// burst sequencer. The master modport is the HS protocol/lane-control side,
// which requests bursts and offers payload words. The slave modport is the
// sequencer, which frames the burst and drives the serializer word lanes.
interface hs_tx_sequencer_if;

    logic       TxRequestHs;
    logic       TxWordValid;
    logic       TxWordReady;
    logic [6:0] InFlip;
    logic [6:0] InRotation;
    logic [6:0] InPolarity;
    logic [6:0] TxFlip;
    logic [6:0] TxRotation;
    logic [6:0] TxPolarity;
    logic       SerializerEn;
    logic       TxBusy;

    modport master (
        output TxRequestHs, TxWordValid, InFlip, InRotation, InPolarity,
        input  TxWordReady, TxFlip, TxRotation, TxPolarity, SerializerEn, TxBusy
    );

    modport slave (
        input  TxRequestHs, TxWordValid, InFlip, InRotation, InPolarity,
        output TxWordReady, TxFlip, TxRotation, TxPolarity, SerializerEn, TxBusy
    );

endinterface

// File: rtl/hs_tx_sequencer.sv
// hs_tx_sequencer: word-rate C-PHY HS burst framer in the TxWordClkHs domain.
// Each burst is sent as PRE_WORDS preamble words, one sync word, the payload
// words (a sync filler on underrun), then POST_WORDS post words. The word
// lanes and SerializerEn are registered. TxWordReady and TxBusy decode the
// current state.
// Optional build macro HS_TX_UNDERRUN_CNT_EN adds the UnderrunCnt[7:0] output.
// UnderrunCnt counts the filler words of the current burst and saturates.
module hs_tx_sequencer
    import hs_tx_pkg::*;
#(
    parameter int PRE_WORDS  = 2,
    parameter int POST_WORDS = 1,
    parameter int CNT_W      = 4
) (
    input  logic             TxWordClkHs,
    input  logic             rst,
    hs_tx_sequencer_if.slave bus
`ifdef HS_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0]       UnderrunCnt
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [WORD_W-1:0]   word;
    logic [WORD_W-1:0]   word_nxt;
    logic                en;
    logic                en_nxt;
`ifdef HS_TX_UNDERRUN_CNT_EN
    logic [7:0]          ucnt;
    logic [7:0]          ucnt_nxt;
`endif

    // Next-state and next-word decode; request is only acted on in IDLE,
    // SYNC and DATA, so pulses during PREAMBLE/POST are ignored.
    always_comb begin
        // NOTE: every signal gets its hold value before the case, so no branch can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        en_nxt    = en;
`ifdef HS_TX_UNDERRUN_CNT_EN
        ucnt_nxt  = ucnt;
`endif
        case (state)
            IDLE: begin
                if (bus.TxRequestHs) begin
                    word_nxt  = PREAMBLE_WORD;
                    en_nxt    = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = PREAMBLE;
`ifdef HS_TX_UNDERRUN_CNT_EN
                    ucnt_nxt  = '0;
`endif
                end
            end
            PREAMBLE: begin
                if (cnt < CNT_W'(PRE_WORDS)) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    word_nxt  = SYNC_WORD;
                    state_nxt = SYNC;
                end
            end
            SYNC, DATA: begin
                if (bus.TxRequestHs) begin
                    state_nxt = DATA;
                    if (bus.TxWordValid) begin
                        word_nxt = {bus.InFlip, bus.InRotation, bus.InPolarity};
                    end else begin
                        // Underrun: keep the line busy with a sync word
                        word_nxt = SYNC_WORD;
`ifdef HS_TX_UNDERRUN_CNT_EN
                        if (ucnt != 8'hFF) begin
                            ucnt_nxt = ucnt + 8'd1;
                        end
`endif
                    end
                end else begin
                    word_nxt  = POST_WORD;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = POST;
                end
            end
            POST: begin
                if (cnt < CNT_W'(POST_WORDS)) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    word_nxt  = '0;
                    en_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                word_nxt  = '0;
                en_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and output word registers; reset aborts a burst at once.
    always_ff @(posedge TxWordClkHs or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
            en    <= 1'b0;
`ifdef HS_TX_UNDERRUN_CNT_EN
            ucnt  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state <= state_nxt;
            cnt   <= cnt_nxt;
            word  <= word_nxt;
            en    <= en_nxt;
`ifdef HS_TX_UNDERRUN_CNT_EN
            ucnt  <= ucnt_nxt;
`endif
        end
    end

    assign bus.TxFlip       = word[20:14];
    assign bus.TxRotation   = word[13:7];
    assign bus.TxPolarity   = word[6:0];
    assign bus.SerializerEn = en;
    assign bus.TxWordReady  = bus.TxRequestHs && ((state == SYNC) || (state == DATA));
    assign bus.TxBusy       = (state != IDLE);
`ifdef HS_TX_UNDERRUN_CNT_EN
    assign UnderrunCnt      = ucnt;
`endif

endmodule

// File: tb/tb_hs_tx_sequencer.sv
// tb_hs_tx_sequencer: scoreboard bench for hs_tx_sequencer.
// DUT a uses PRE_WORDS=2 and POST_WORDS=1. DUT b uses PRE_WORDS=1 and
// POST_WORDS=3. The bench requests a burst from only one DUT at a time.
// When a burst is issued, the driver builds the expected word stream from the
// framing rules and queues it. A negedge monitor pops one word per enabled
// cycle. While the serializer is disabled, the monitor checks for zero outputs.
module tb_hs_tx_sequencer;

    localparam int PRE_A  = 2;
    localparam int POST_A = 1;
    localparam int PRE_B  = 1;
    localparam int POST_B = 3;

    // Framing words {Flip, Rotation, Polarity} as listed for the C-PHY burst
    localparam logic [20:0] W_PRE  = {7'h00, 7'h7F, 7'h7F};
    localparam logic [20:0] W_SYNC = {7'h3E, 7'h41, 7'h41};
    localparam logic [20:0] W_POST = {7'h7F, 7'h00, 7'h00};

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        req   = 1'b0;
    logic        valid = 1'b0;
    logic [20:0] din   = '0;
    logic        sel   = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int en_cnt_a = 0;
    int en_cnt_b = 0;
    logic [20:0] q_a[$];
    logic [20:0] q_b[$];

    initial forever #5 clk = ~clk;

    hs_tx_sequencer_if bus_a ();
    hs_tx_sequencer_if bus_b ();

    assign bus_a.TxRequestHs = req & ~sel;
    assign bus_a.TxWordValid = valid;
    assign bus_a.InFlip      = din[20:14];
    assign bus_a.InRotation  = din[13:7];
    assign bus_a.InPolarity  = din[6:0];
    assign bus_b.TxRequestHs = req & sel;
    assign bus_b.TxWordValid = valid;
    assign bus_b.InFlip      = din[20:14];
    assign bus_b.InRotation  = din[13:7];
    assign bus_b.InPolarity  = din[6:0];

`ifdef HS_TX_UNDERRUN_CNT_EN
    logic [7:0] ucnt_a;
    logic [7:0] ucnt_b;
    wire  [7:0] ucnt_sel = sel ? ucnt_b : ucnt_a;
`endif

    hs_tx_sequencer #(.PRE_WORDS(PRE_A), .POST_WORDS(POST_A), .CNT_W(4)) dut_a (
        .TxWordClkHs (clk),
        .rst         (rst),
        .bus         (bus_a.slave)
`ifdef HS_TX_UNDERRUN_CNT_EN
        ,
        .UnderrunCnt (ucnt_a)
`endif
    );

    hs_tx_sequencer #(.PRE_WORDS(PRE_B), .POST_WORDS(POST_B), .CNT_W(4)) dut_b (
        .TxWordClkHs (clk),
        .rst         (rst),
        .bus         (bus_b.slave)
`ifdef HS_TX_UNDERRUN_CNT_EN
        ,
        .UnderrunCnt (ucnt_b)
`endif
    );

    wire [20:0] out_a = {bus_a.TxFlip, bus_a.TxRotation, bus_a.TxPolarity};
    wire [20:0] out_b = {bus_b.TxFlip, bus_b.TxRotation, bus_b.TxPolarity};
    wire        rdy   = sel ? bus_b.TxWordReady : bus_a.TxWordReady;
    wire        bsy   = sel ? bus_b.TxBusy : bus_a.TxBusy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [20:0] w);
        if (sel) q_b.push_back(w);
        else     q_a.push_back(w);
    endtask

    // Monitor body for one DUT: consume one expected word per enabled cycle
    task automatic mon(input bit id, input logic en, input logic [20:0] w, input logic busy);
        string p;
        logic [20:0] e;
        p = id ? "b" : "a";
        if (en) begin
            if (id) en_cnt_b++;
            else    en_cnt_a++;
            check({p, "_busy_while_en"}, 32'(busy), 32'd1);
            if ((id ? q_b.size() : q_a.size()) == 0) begin
                check({p, "_spurious_en"}, 32'(en), 32'd0);
            end else begin
                e = id ? q_b.pop_front() : q_a.pop_front();
                check({p, "_word"}, 32'(w), 32'(e));
            end
        end else begin
            check({p, "_idle_word"}, 32'(w), 32'd0);
            check({p, "_idle_busy"}, 32'(busy), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, bus_a.SerializerEn, out_a, bus_a.TxBusy);
        mon(1'b1, bus_b.SerializerEn, out_b, bus_b.TxBusy);
    end

    // Asynchronous reset in mid-cycle; outputs must clear before any edge
    task automatic do_reset();
        #1 rst = 1'b0;
        #1;
        check("rst_a_en",   32'(bus_a.SerializerEn), 32'd0);
        check("rst_a_word", 32'(out_a), 32'd0);
        check("rst_a_busy", 32'(bus_a.TxBusy), 32'd0);
        check("rst_b_en",   32'(bus_b.SerializerEn), 32'd0);
        check("rst_b_word", 32'(out_b), 32'd0);
`ifdef HS_TX_UNDERRUN_CNT_EN
        check("rst_ucnt", 32'(ucnt_sel), 32'd0);
`endif
        q_a.delete();
        q_b.delete();
        req   = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles: no request, nothing ready, nothing busy
    task automatic idle(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) begin
            valid = 1'(1'($urandom_range(0, 1)));
            din   = 21'($urandom);
            #1;
            check("idle_ready", 32'(rdy), 32'd0);
            check("idle_busy_drv", 32'(bsy), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // One burst on the selected DUT: n payload slots, vmask bit k = word
    // offered in slot k, b2b = hold request through POST, abort_at = cycle
    // index at which reset is pulled (-1: none), first[21] = fixed slot 0 word.
    task automatic burst(input int n, input logic [31:0] vmask, input bit b2b,
                         input int abort_at, input logic [21:0] first);
        int pre;
        int post;
        int total;
        int fill;
        logic [20:0] data[32];
        bit r;
        bit v;
        bit er;
        logic [20:0] d;
        pre  = sel ? PRE_B : PRE_A;
        post = sel ? POST_B : POST_A;
        fill = 0;
        for (int k = 0; k < n; k++) data[k] = 21'($urandom);
        if (first[21]) data[0] = first[20:0];
        for (int k = 0; k < pre; k++) push(W_PRE);
        push(W_SYNC);
        for (int k = 0; k < n; k++) begin
            push(vmask[k] ? data[k] : W_SYNC);
            if (!vmask[k]) fill++;
        end
        for (int k = 0; k < post; k++) push(W_POST);
        if (sel) en_cnt_b = 0;
        else     en_cnt_a = 0;
        total = 1 + pre + n + 1 + post;
        for (int c = 0; c < total; c++) begin
            er = 1'b0;
            v  = 1'(1'($urandom_range(0, 1)));
            d  = 21'($urandom);
            if (c == 0) begin
                r = 1'b1;
            end else if (c <= pre) begin
                r = 1'(1'($urandom_range(0, 1)));
            end else if (c <= pre + n) begin
                r  = 1'b1;
                v  = vmask[c - pre - 1];
                d  = data[c - pre - 1];
                er = 1'b1;
            end else if (c == pre + n + 1) begin
                r = 1'b0;
                v = 1'b1;
            end else begin
                r = b2b ? 1'b1 : 1'(1'($urandom_range(0, 1)));
            end
            req   = r;
            valid = v;
            din   = d;
            #1;
            check("ready", 32'(rdy), 32'(er));
            check("busy", 32'(bsy), 32'(c != 0));
            if (c == abort_at) begin
                do_reset();
                return;
            end
            @(posedge clk);
            #1;
        end
        check("burst_len", 32'(sel ? en_cnt_b : en_cnt_a), 32'(pre + 1 + n + post));
`ifdef HS_TX_UNDERRUN_CNT_EN
        check("underrun_cnt", 32'(ucnt_sel), 32'(fill > 255 ? 255 : fill));
`endif
    endtask

    task automatic random_bursts(input int count);
        bit b2b;
        for (int i = 0; i < count; i++) begin
            b2b = (i != count - 1) && ($urandom_range(0, 2) == 0);
            burst($urandom_range(1, 6), 32'($urandom), b2b, -1, '0);
            if (!b2b) idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        #2;
        check("por_a_en",   32'(bus_a.SerializerEn), 32'd0);
        check("por_a_word", 32'(out_a), 32'd0);
        check("por_a_busy", 32'(bus_a.TxBusy), 32'd0);
        check("por_b_en",   32'(bus_b.SerializerEn), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // DUT a: single payload word 0x55/0x2A/0x11
        sel = 1'b0;
        burst(1, 32'h1, 1'b0, -1, {1'b1, 7'h55, 7'h2A, 7'h11});
        idle(2);
        // Three fillers among five slots
        burst(5, 32'b10001, 1'b0, -1, '0);
        idle(1);
        // Back-to-back: request held through POST, one idle word in between
        burst(3, 32'($urandom), 1'b1, -1, '0);
        burst(2, 32'b11, 1'b0, -1, '0);
        idle(2);
        // Reset during PREAMBLE, then during DATA
        burst(3, 32'b111, 1'b0, 1, '0);
        idle(3);
        burst(3, 32'b101, 1'b0, PRE_A + 2, '0);
        idle(3);
        random_bursts(10);

        // DUT b: one preamble word, three post words
        sel = 1'b1;
        burst(1, 32'h1, 1'b0, -1, {1'b1, 7'h55, 7'h2A, 7'h11});
        idle(2);
        burst(4, 32'b0000, 1'b0, -1, '0);
        burst(3, 32'($urandom), 1'b1, -1, '0);
        burst(2, 32'($urandom), 1'b0, -1, '0);
        idle(2);
        burst(2, 32'b11, 1'b0, PRE_B + 2, '0);
        idle(3);
        random_bursts(10);

        sel = 1'b0;
        idle(4);
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
